// File: rtl/gpio_pkg.sv
// Shared GPIO input definitions: default width, default debounce length and vector type.
package gpio_pkg;
  localparam int GPIO_WIDTH          = 9;
  localparam int GPIO_DB_CNT_DEFAULT = 4;

  typedef logic [GPIO_WIDTH-1:0] gpio_vec_t;
endpackage

// File: rtl/gpio_bit_debounce.sv
// One GPIO bit: two-flop synchroniser, qualify counter and stable flop.
// flip_o pulses in the cycle whose edge flips the stable value.
module gpio_bit_debounce #(
  parameter int DB_CNT = 4,
  parameter int CNT_W  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o,
  output logic flip_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CNT - 1);

  logic             s1_q, s2_q, stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle where s2 matches stable restarts qualification.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    flip_o   = 1'b0;
    if (s2_q != stable_q) begin
      if (cnt_q == LAST) begin
        stable_d = s2_q;
        flip_o   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
endmodule

// File: rtl/gpio_in_conditioner.sv
// GPIO input conditioner: per-bit sync + debounce, sticky change flags with
// set-wins clear. Define GPIO_IRQ_EN to add the masked gpio_irq output.
module gpio_in_conditioner
  import gpio_pkg::*;
#(
  parameter int WIDTH  = GPIO_WIDTH,
  parameter int DB_CNT = GPIO_DB_CNT_DEFAULT,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gpio_raw_in,
  output logic [WIDTH-1:0] gpio_port_out,
  output logic [WIDTH-1:0] change_flags,
  input  logic             flag_clr_we,
  input  logic [WIDTH-1:0] flag_clr_mask
`ifdef GPIO_IRQ_EN
  ,
  input  logic [WIDTH-1:0] irq_mask,
  output logic             gpio_irq
`endif
);
  logic [WIDTH-1:0] flip, flags_q, flags_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_bit_debounce #(.DB_CNT(DB_CNT), .CNT_W(CNT_W)) u_db (
      .clk      (clk),
      .reset    (reset),
      .raw_i    (gpio_raw_in[i]),
      .stable_o (gpio_port_out[i]),
      .flip_o   (flip[i])
    );
  end

  // Set is OR-ed after the clear so a flip coinciding with a clear is kept.
  always_comb begin
    flags_d = flags_q;
    if (flag_clr_we) flags_d = flags_d & ~flag_clr_mask;
    flags_d = flags_d | flip;
  end

  always_ff @(posedge clk) begin
    if (reset) flags_q <= '0;
    else       flags_q <= flags_d;
  end

  assign change_flags = flags_q;

`ifdef GPIO_IRQ_EN
  logic irq_q;

  // Computed from the next flag value so the IRQ lines up with the flag.
  always_ff @(posedge clk) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= |(flags_d & irq_mask);
  end

  assign gpio_irq = irq_q;
`endif
endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed bench for gpio_in_conditioner (WIDTH=9, DB_CNT=4); IRQ checks
// are active when GPIO_IRQ_EN is defined.
module tb_gpio_in_conditioner;
  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] gpio_raw_in, gpio_port_out, change_flags, flag_clr_mask;
  logic       flag_clr_we;
`ifdef GPIO_IRQ_EN
  logic [8:0] irq_mask;
  logic       gpio_irq;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gpio_in_conditioner #(.WIDTH(9), .DB_CNT(4), .CNT_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .gpio_raw_in   (gpio_raw_in),
    .gpio_port_out (gpio_port_out),
    .change_flags  (change_flags),
    .flag_clr_we   (flag_clr_we),
    .flag_clr_mask (flag_clr_mask)
`ifdef GPIO_IRQ_EN
    ,
    .irq_mask      (irq_mask),
    .gpio_irq      (gpio_irq)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%03h expected 0x%03h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr(input logic [8:0] m);
    flag_clr_we   = 1'b1;
    flag_clr_mask = m;
    step(1);
    flag_clr_we   = 1'b0;
    flag_clr_mask = '0;
  endtask

  initial begin
    reset         = 1'b1;
    gpio_raw_in   = '0;
    flag_clr_we   = 1'b0;
    flag_clr_mask = '0;
`ifdef GPIO_IRQ_EN
    irq_mask      = 9'h002;
`endif
    step(2);
    chk("rst_port", 16'(gpio_port_out), 16'h000);
    chk("rst_flags", 16'(change_flags), 16'h000);
    reset = 1'b0;

    // Basic propagation: six edges from raw change to output.
    gpio_raw_in = 9'h001;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      chk($sformatf("lat_hold_e%0d", k), 16'(gpio_port_out), 16'h000);
    end
    step(1);
    chk("lat_port_e6", 16'(gpio_port_out), 16'h001);
    chk("lat_flags_e6", 16'(change_flags), 16'h001);
`ifdef GPIO_IRQ_EN
    chk("irq_masked_bit0", 16'(gpio_irq), 16'h000);
`endif

    // Glitch: bit 3 high for 3 cycles is suppressed.
    gpio_raw_in = 9'h009;
    step(3);
    gpio_raw_in = 9'h001;
    step(8);
    chk("glitch3_port", 16'(gpio_port_out), 16'h001);
    chk("glitch3_flags", 16'(change_flags), 16'h001);

    // Four cycles is the minimum accepted pulse.
    gpio_raw_in = 9'h009;
    step(4);
    gpio_raw_in = 9'h001;
    step(1);
    chk("pulse4_pre", 16'(gpio_port_out), 16'h001);
    step(1);
    chk("pulse4_port", 16'(gpio_port_out), 16'h009);
    chk("pulse4_flags", 16'(change_flags), 16'h009);
    step(8);
    chk("pulse4_back", 16'(gpio_port_out), 16'h001);

    // Clear ignored without strobe, then effective with it.
    flag_clr_mask = 9'h009;
    step(1);
    chk("clr_no_we", 16'(change_flags), 16'h009);
    clr(9'h009);
    chk("clr_we", 16'(change_flags), 16'h000);
    clr(9'h001);
    chk("clr_idle", 16'(change_flags), 16'h000);

    // Set wins: clear bit 0 on the same edge it flips back to 0.
    gpio_raw_in = 9'h000;
    step(5);
    clr(9'h001);
    chk("setwin_port", 16'(gpio_port_out), 16'h000);
    chk("setwin_flags", 16'(change_flags), 16'h001);
    clr(9'h1FF);

    // All bits flip on one edge.
    gpio_raw_in = 9'h1FF;
    step(5);
    chk("multi_pre", 16'(gpio_port_out), 16'h000);
    step(1);
    chk("multi_port", 16'(gpio_port_out), 16'h1FF);
    chk("multi_flags", 16'(change_flags), 16'h1FF);
    clr(9'h0F0);
    chk("multi_clr", 16'(change_flags), 16'h10F);

    // Reset mid-count discards the partial qualification.
    reset = 1'b1;
    gpio_raw_in = 9'h000;
    step(1);
    reset = 1'b0;
    chk("rst2_port", 16'(gpio_port_out), 16'h000);
    chk("rst2_flags", 16'(change_flags), 16'h000);
    gpio_raw_in = 9'h002;
    step(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("midrst_port", 16'(gpio_port_out), 16'h000);
    chk("midrst_flags", 16'(change_flags), 16'h000);
    step(5);
    chk("midrst_hold", 16'(gpio_port_out), 16'h000);
    step(1);
    chk("midrst_port_e6", 16'(gpio_port_out), 16'h002);
    chk("midrst_flags_e6", 16'(change_flags), 16'h002);
`ifdef GPIO_IRQ_EN
    chk("irq_set", 16'(gpio_irq), 16'h001);
    clr(9'h002);
    chk("irq_clr", 16'(gpio_irq), 16'h000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/gpio_in_conditioner.md
Name: gpio_in_conditioner

Overview:
Input-side conditioner that sits directly upstream of the RISC-V pipeline core's gpio_port_in.
- Synchronises raw, asynchronous board pins into clk.
- Debounces each bit independently.
- Presents a stable vector to the core.
- Keeps sticky per-bit change flags that core software can poll and clear.

Parameters:
- WIDTH, 9: number of GPIO input bits; matches the core's gpio_port_in.
- DB_CNT, 4: consecutive synchronised cycles a bit must differ from its stable value before the stable value flips; legal range 1..255.
- CNT_W, 8: width of each per-bit debounce counter; must satisfy 2^CNT_W > DB_CNT.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- gpio_raw_in  input  WIDTH  asynchronous pin levels from the board.
- gpio_port_out  output  WIDTH  debounced stable vector; drives the core's gpio_port_in.
- change_flags  output  WIDTH  sticky flag per bit; set on any stable-value transition.
- flag_clr_we  input  1  one-cycle clear strobe from the core's store path.
- flag_clr_mask  input  WIDTH  bits to clear when flag_clr_we=1.

Behaviour:
- Reset (reset=1 at a clk edge):
  - Both sync stages, stable register, all counters and change_flags go to 0.
  - gpio_port_out=0 and change_flags=0 from the edge after reset is sampled high.
  - A reset asserted mid-count discards the count, with no partial flip.
- Sync: two flop stages per bit (s1<=gpio_raw_in, s2<=s1). No logic between s1 and s2.
- Debounce, per bit i, evaluated each cycle:
  - s2[i]==stable[i]: cnt[i]<=0.
  - s2[i]!=stable[i] and cnt[i]<DB_CNT-1: cnt[i]<=cnt[i]+1.
  - s2[i]!=stable[i] and cnt[i]==DB_CNT-1: stable[i]<=s2[i], cnt[i]<=0.
  - A single matching cycle restarts the count. There is no hysteresis beyond this.
  - DB_CNT=1: stable follows s2 with one extra cycle of delay.
- Latency: a raw level held steady from edge N appears on gpio_port_out at edge N+1+DB_CNT+1. That is 6 edges for DB_CNT=4: 2 sync stages plus DB_CNT qualify cycles, with the flip on the last of them.
- Minimum accepted pulse: DB_CNT cycles at s2. Shorter pulses are fully suppressed.
- gpio_port_out is the stable register driven directly, with no combinational path from gpio_raw_in.
- Change flags:
  - Set condition for change_flags[i]: stable[i] flips this cycle.
  - Clear condition: flag_clr_we & flag_clr_mask[i].
  - Set and clear in the same cycle: set wins, so no event is lost.
  - Clear with flag_clr_we=0 is ignored. Clearing an already-clear bit is a no-op.
- Bits are fully independent. Simultaneous flips on several bits all update in the same cycle.
- Counters never exceed DB_CNT-1, so there is no wrap-around.

Optional Feature:
- Macro GPIO_IRQ_EN.
- Defined:
  - Adds output port gpio_irq (1 bit) and input port irq_mask (WIDTH).
  - gpio_irq is registered: gpio_irq <= |(change_flags_next & irq_mask), where change_flags_next is the value change_flags takes at that edge, so gpio_irq is asserted in the same cycle the flag is visible.
  - It stays high while any unmasked flag is set.
  - Reset value 0.
- Undefined: neither port exists and no IRQ logic is built. Everything else is identical.

Decomposition:
- Shared package gpio_pkg holds:
  - GPIO_WIDTH=9 and GPIO_DB_CNT_DEFAULT=4.
  - The gpio_vec_t typedef (logic [GPIO_WIDTH-1:0]).
- Natural sub-module: gpio_bit_debounce, one bit containing sync flops, counter and stable flop, with a one-cycle flip pulse output.
  - Instantiate WIDTH copies with a generate loop.
  - Flags, clear and IRQ logic stay in the top.

Test Plan (WIDTH=9, DB_CNT=4):
- Basic propagation: reset high 2 cycles then low; gpio_raw_in=0x001 steady -> gpio_port_out stays 0x000 for 5 edges, becomes 0x001 on edge 6, change_flags=0x001.
- Glitch rejection: raw bit 3 high for 3 cycles then low -> gpio_port_out and change_flags unchanged (0x000). Holding it high for 4 cycles -> the flip occurs.
- Clear, and set-wins: with change_flags=0x001, flag_clr_we=1 and mask=0x001 -> flags=0x000 next edge. Clearing bit 0 in the same cycle bit 0 flips again -> flags[0]=1.
- Multi-bit: raw 0x1FF from 0 -> all bits flip on the same edge, change_flags=0x1FF. Clear with mask=0x0F0 -> flags=0x10F.
- Reset mid-count: raw 0x002, assert reset at qualify cycle 2 for 1 cycle -> outputs 0. The flip occurs only 6 edges after reset deasserts.
- GPIO_IRQ_EN: irq_mask=0x002, bit 1 flips -> gpio_irq=1 in the same cycle change_flags[1] is visible. A bit-0 flip alone leaves gpio_irq=0. Clearing flag 1 drops gpio_irq next edge.
